conv_line_reader: RTL and testbench

//  Read-side counterpart of the conv line buffer. Takes conv result pixels as a

---
 rtl/conv_pkg.sv | 12 +
 rtl/conv_line_reader_if.sv | 23 ++
 rtl/sync_fifo_fwft.sv | 52 +++++
 rtl/conv_line_reader.sv | 123 ++++++++++++
 tb/tb_conv_line_reader.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv line buffer / line reader pair.
package conv_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/conv_line_reader_if.sv
// Pixel stream bundle: unstallable input side, valid/ready raster output side.
interface conv_line_reader_if #(
    parameter int WIDTH = conv_pkg::PIX_W
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_sof;
    logic             dout_eol;
    logic             dout_eof;

    modport master (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, dout_sof, dout_eol, dout_eof
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, dout_sof, dout_eol, dout_eof
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: head always presents the oldest entry.
module sync_fifo_fwft #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [WIDTH-1:0]  din,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign full    = (level == (ADDR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/conv_line_reader.sv
// Buffers an unstallable conv pixel stream and replays it line by line as
// framed raster bursts under downstream backpressure.
module conv_line_reader import conv_pkg::*; #(
    parameter int WIDTH      = PIX_W,
    parameter int IMG_WIDTH  = 480,
    parameter int IMG_HEIGHT = 480,
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    conv_line_reader_if.slave   bus,
    output logic                frame_done,
    output logic [ADDR_W:0]     fifo_level,
    output logic                overflow
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W:0]   LVL_LINE = (ADDR_W+1)'(IMG_WIDTH);
    localparam logic [ADDR_W:0]   LVL_MAX  = (ADDR_W+1)'(DEPTH);

    rd_state_t          state, state_nx;
    logic [COL_W-1:0]   col, col_nx;
    logic [ROW_W-1:0]   row, row_nx;
    logic [WIDTH-1:0]   pix, head;
    logic [ADDR_W:0]    fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               load, lvl_full, accept;
    logic               out_vld, last_col, last_row;

    assign out_vld  = (state == S_BURST);
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // The pixel parked in the output register still counts as buffered, so
    // capacity stays DEPTH in total across FIFO and output stage.
    assign fifo_level = fifo_cnt + {{ADDR_W{1'b0}}, out_vld};
    assign lvl_full   = fifo_full | (fifo_level == LVL_MAX);
    assign accept     = bus.din_valid & ~lvl_full;

    sync_fifo_fwft #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (accept),
        .din   (bus.din),
        .pop   (load),
        .head  (head),
        .level (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= S_IDLE;
        else if (clr) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_level >= LVL_LINE) begin
                    state_nx = S_BURST;
                    load     = ~fifo_empty;
                end
            end
            S_BURST: begin
                if (bus.dout_ready) begin
                    if (last_col) begin
                        state_nx = S_GAP;
                        col_nx   = '0;
                    end else begin
                        col_nx = col + 1'b1;
                        load   = ~fifo_empty;
                    end
                end
            end
            S_GAP: begin
                state_nx = S_IDLE;
                row_nx   = last_row ? '0 : row + 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            pix      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            col      <= '0;
            row      <= '0;
            pix      <= '0;
            overflow <= 1'b0;
        end else begin
            col <= col_nx;
            row <= row_nx;
            if (load) pix <= head;
            if (bus.din_valid && lvl_full) overflow <= 1'b1;
        end
    end

    assign bus.dout       = pix;
    assign bus.dout_valid = out_vld;
    assign bus.dout_sof   = out_vld && (row == '0) && (col == '0);
    assign bus.dout_eol   = out_vld && last_col;
    assign bus.dout_eof   = out_vld && last_col && last_row;
    assign frame_done     = (state == S_GAP) && last_row;
endmodule

// File: tb/tb_conv_line_reader.sv
// Directed bench for conv_line_reader with a 4x2 frame and 8-entry FIFO.
module tb_conv_line_reader;
    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int D  = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic       frame_done;
    logic       overflow;
    logic [3:0] fifo_level;
    int         total = 0;
    int         bad   = 0;

    conv_line_reader_if #(.WIDTH(W)) bus();

    conv_line_reader #(
        .WIDTH      (W),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .DEPTH      (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .frame_done (frame_done),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes nwr pixels from base while checking nexp outputs base.. in order.
    // Masks give the hand-computed sof/eol/eof per output index.
    task automatic stream(input string tag, input int nwr, input logic [7:0] base,
                          input bit alt, input int nexp,
                          input logic [15:0] sofm, input logic [15:0] eolm,
                          input logic [15:0] eofm, input int lv_lo, input int lv_hi,
                          input logic [3:0] lv_exp, output int nvld);
        int k = 0;
        int w = 0;
        nvld = 0;
        for (int c = 0; c < 64 && k < nexp; c++) begin
            bus.din_valid  = (w < nwr);
            bus.din        = base + 8'(w);
            if (w < nwr) w++;
            bus.dout_ready = alt ? (c % 2 == 0) : 1'b1;
            if (c >= lv_lo && c <= lv_hi) chk({tag, "_lvl"}, fifo_level, lv_exp);
            if (bus.dout_valid) begin
                nvld++;
                chk({tag, "_dout"}, bus.dout, base + 8'(k));
                chk({tag, "_sof"}, bus.dout_sof, sofm[k]);
                chk({tag, "_eol"}, bus.dout_eol, eolm[k]);
                chk({tag, "_eof"}, bus.dout_eof, eofm[k]);
                if (bus.dout_ready) k++;
            end else begin
                chk({tag, "_idle_flags"}, {bus.dout_sof, bus.dout_eol, bus.dout_eof}, 0);
            end
            tick();
        end
        bus.din_valid = 1'b0;
        chk({tag, "_count"}, k, nexp);
    endtask

    initial begin
        int nv;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        chk("rst_vld", bus.dout_valid, 0);
        chk("rst_lvl", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_dout", bus.dout, 0);
        rst_n = 1'b1;
        tick();

        // Single line, row 0, back-to-back output.
        stream("t1", 4, 8'h10, 1'b0, 4, 16'h1, 16'h8, 16'h0, 99, 0, 4'd0, nv);
        chk("t1_bubbles", nv, 4);
        chk("t1_gap_vld", bus.dout_valid, 0);
        chk("t1_fd", frame_done, 0);
        chk("t1_lvl", fifo_level, 0);
        tick();

        // Row 1 buffered first, then alternating ready; this line ends the frame.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.din       = 8'h20 + 8'(i);
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        chk("t2_lvl", fifo_level, 4);
        chk("t2_vld_idle", bus.dout_valid, 0);
        stream("t2", 0, 8'h20, 1'b1, 4, 16'h0, 16'h8, 16'h8, 99, 0, 4'd0, nv);
        chk("t2_fd", frame_done, 1);
        chk("t2_gap_vld", bus.dout_valid, 0);
        tick();
        chk("t2_fd_pulse", frame_done, 0);

        // Whole frame (two lines) with writes overlapping the first burst.
        stream("t3", 8, 8'h30, 1'b0, 8, 16'h01, 16'h88, 16'h80, 5, 8, 4'd5, nv);
        chk("t3_fd", frame_done, 1);
        chk("t3_lvl", fifo_level, 0);
        tick();
        chk("t3_fd_pulse", frame_done, 0);
        stream("t3_next", 4, 8'h40, 1'b0, 4, 16'h1, 16'h8, 16'h0, 99, 0, 4'd0, nv);
        tick();

        // Overflow: ready held low, 9 writes, 9th dropped.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.din       = 8'h50 + 8'(i);
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        chk("t4_lvl", fifo_level, 8);
        chk("t4_ovf", overflow, 1);
        chk("t4_vld", bus.dout_valid, 1);
        chk("t4_head", bus.dout, 8'h50);
        stream("t4", 0, 8'h50, 1'b0, 8, 16'h10, 16'h88, 16'h08, 99, 0, 4'd0, nv);
        chk("t4_lvl_end", fifo_level, 0);
        chk("t4_ovf_sticky", overflow, 1);
        tick();
        tick();
        chk("t4_no_extra", bus.dout_valid, 0);

        // Continuous input while bursting: level constant over write+pop cycles.
        stream("t5", 8, 8'h60, 1'b0, 8, 16'h10, 16'h88, 16'h08, 5, 8, 4'd5, nv);
        chk("t5_lvl_end", fifo_level, 0);
        tick();

        // Synchronous clear mid-burst.
        stream("t6a", 4, 8'h70, 1'b0, 2, 16'h0, 16'h0, 16'h0, 99, 0, 4'd0, nv);
        chk("t6_pre_vld", bus.dout_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_clr_vld", bus.dout_valid, 0);
        chk("t6_clr_lvl", fifo_level, 0);
        chk("t6_clr_ovf", overflow, 0);
        stream("t6b", 4, 8'h80, 1'b0, 4, 16'h1, 16'h8, 16'h0, 99, 0, 4'd0, nv);
        tick();

        // Asynchronous reset mid-burst on a row-1 line.
        stream("t6c", 4, 8'h90, 1'b0, 2, 16'h0, 16'h0, 16'h0, 99, 0, 4'd0, nv);
        chk("t6_pre_rst_vld", bus.dout_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", bus.dout_valid, 0);
        chk("t6_rst_lvl", fifo_level, 0);
        chk("t6_rst_dout", bus.dout, 0);
        chk("t6_rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        stream("t6d", 4, 8'hA0, 1'b0, 4, 16'h1, 16'h8, 16'h0, 99, 0, 4'd0, nv);
        chk("t6d_fd", frame_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
